mpdmac_cfg: RTL and testbench
=============================

# mpdmac_cfg

APB-slave configuration and status block sitting directly upstream of the mirror-padding DMA engine. It holds the source address, destination address and matrix width SFRs and issues a single-cycle start pulse to the engine. It tracks engine completion through the engine's `done` level and raises a maskable interrupt on completion or on a rejected start.

## Interface
Parameters:
- VERSION, 32'h0001_2024: value returned by the VERSION register.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- psel_i  in  1  APB select
- penable_i  in  1  APB enable (access phase)
- paddr_i  in  12  APB byte address; bits [1:0] ignored
- pwrite_i  in  1  APB write
- pwdata_i  in  32  APB write data
- pready_o  out  1  APB ready; constant 1 (zero wait states)
- prdata_o  out  32  APB read data, registered
- src_addr_o  out  32  to engine: source base address
- dst_addr_o  out  32  to engine: destination base address
- mat_width_o  out  6  to engine: source matrix width N (output is (N+2)x(N+2))
- start_o  out  1  to engine: one-cycle start pulse
- done_i  in  1  from engine: 1 = idle/finished, 0 = transfer in progress
- irq_o  out  1  level interrupt, high while any enabled INT_STATUS bit is set

## Operation
- Register map (unmapped offsets read 0; writes to them are ignored):
  - 0x000 VERSION, RO.
  - 0x100 SRC_ADDR, RW, 32 bits.
  - 0x104 DST_ADDR, RW, 32 bits.
  - 0x108 MAT_WIDTH, RW, bits [5:0]; upper bits read 0.
  - 0x10C START, WO; writing bit0 = 1 requests a start; reads 0.
  - 0x110 STATUS, RO: bit0 = done_i, bit1 = busy, bit2 = last START request rejected.
  - 0x114 INT_STATUS, W1C: bit0 = transfer complete, bit1 = start rejected.
  - 0x118 INT_ENABLE, RW, bits [1:0].
- Writes take effect on the APB access phase (psel_i & penable_i & pwrite_i).
- SRC/DST/WIDTH may be written while busy. The engine latches them at start, so a write during a transfer affects only the next transfer.
- Start acceptance:
  - A request is accepted when busy = 0, done_i = 1 and MAT_WIDTH >= 3.
  - On acceptance: start_o = 1 for exactly one cycle, busy is set, STATUS.bit2 is cleared.
  - Otherwise the request is rejected: no pulse, STATUS.bit2 = 1, INT_STATUS.bit1 is set.
- Completion:
  - done_d holds done_i registered.
  - A rising edge (done_i & !done_d) while busy clears busy and sets INT_STATUS.bit0.
  - A rising edge while not busy is ignored.
- W1C: writing 1 clears the INT_STATUS bit. If a set event occurs in the same cycle as the clear, the set wins.
- irq_o = |(INT_STATUS & INT_ENABLE), registered.

## Timing
- Reset values:
  - prdata_o, start_o, irq_o: 0. pready_o: 1.
  - SRC_ADDR, DST_ADDR, MAT_WIDTH, INT_STATUS, INT_ENABLE: 0.
  - busy: 0. STATUS.bit2: 0. done_d: 1 (so the engine's reset-high done does not produce a false edge).
- Read data is captured in the setup phase (psel_i & !penable_i) into prdata_o and is valid throughout the access phase. prdata_o holds its value otherwise.
- Register writes are visible on the outputs and in reads from the cycle after the access phase.
- start_o is asserted in the cycle after the START write access phase.
- The engine drops done_i one cycle after start_o. busy covers that gap, so a second START issued back-to-back is rejected.
- INT_STATUS.bit0 is set the cycle after done_i rises. irq_o follows one cycle later.
- Reset mid-transfer clears busy and all interrupt state. No completion is reported for the aborted transfer.

## Configuration
- MPDMAC_IRQ_EN defined: INT_STATUS, INT_ENABLE and irq_o are implemented as described above.
- MPDMAC_IRQ_EN undefined:
  - INT_STATUS and INT_ENABLE read 0 and writes to them are ignored.
  - irq_o is tied to 0.
  - STATUS (including bit2) and start gating are unchanged.

## Test plan
- Reset, then read VERSION, SRC_ADDR and STATUS -> 0x0001_2024, 0x0, 0x1.
- Write SRC = 0x1000, DST = 0x2000, WIDTH = 4, INT_ENABLE = 3, START = 1, with the engine model dropping done for 20 cycles -> one start_o pulse; outputs 0x1000 / 0x2000 / 4; STATUS = 0x2 while busy. When done rises: INT_STATUS = 0x1, then irq_o = 1 one cycle later.
- Write START twice back-to-back -> exactly one start_o pulse; STATUS.bit2 = 1; INT_STATUS.bit1 = 1.
- Write WIDTH = 2, then START = 1 -> no start_o; STATUS = 0x5; INT_STATUS = 0x2.
- Write INT_STATUS = 0x1 in the same cycle that done rises -> bit0 remains 1. A later write of 0x1 clears it and irq_o falls.
- Build without MPDMAC_IRQ_EN and repeat the second scenario -> irq_o stays 0 and INT_STATUS reads 0.

Source files
------------

// File: rtl/mpdmac_cfg.sv
`timescale 1ns/1ps
// mpdmac_cfg
// APB configuration/status block for the mirror-padding DMA engine.
// Holds SRC/DST/WIDTH SFRs, issues a one-cycle start pulse, tracks completion
// through the engine's done level and reports it through a maskable interrupt.
//
// Build option: define MPDMAC_IRQ_EN to implement INT_STATUS, INT_ENABLE and
// irq_o. Without it those registers read 0, ignore writes and irq_o is 0.
//
// Handshake: APB with zero wait states. pready_o is tied high, so every access
// phase (psel_i & penable_i) completes in one cycle. Read data is captured in
// the setup phase (psel_i & !penable_i) and held until the next setup phase;
// writes commit on the access phase and are visible from the next cycle.
//
// The busy flag is a two-state FSM (IDLE/BUSY); its state is exposed through
// STATUS.bit1 for observation.

module mpdmac_cfg #(
  parameter logic [31:0] VERSION = 32'h0001_2024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        psel_i,
  input  logic        penable_i,
  input  logic [11:0] paddr_i,
  input  logic        pwrite_i,
  input  logic [31:0] pwdata_i,
  output logic        pready_o,
  output logic [31:0] prdata_o,
  output logic [31:0] src_addr_o,
  output logic [31:0] dst_addr_o,
  output logic [5:0]  mat_width_o,
  output logic        start_o,
  input  logic        done_i,
  output logic        irq_o
);

  // Word offsets (byte address >> 2).
  localparam logic [9:0] A_VERSION = 10'h000;
  localparam logic [9:0] A_SRC     = 10'h040;
  localparam logic [9:0] A_DST     = 10'h041;
  localparam logic [9:0] A_WIDTH   = 10'h042;
  localparam logic [9:0] A_START   = 10'h043;
  localparam logic [9:0] A_STATUS  = 10'h044;
  localparam logic [9:0] A_ISTAT   = 10'h045;
  localparam logic [9:0] A_IEN     = 10'h046;

  // Smallest source width the engine can pad.
  localparam logic [5:0] MIN_WIDTH = 6'd3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] src_q, src_d;
  logic [31:0] dst_q, dst_d;
  logic [5:0]  width_q, width_d;
  logic        rej_q, rej_d;
  logic        start_q, start_d;
  logic        done_q;
  logic [31:0] prdata_q, prdata_d;

  logic [9:0]  word_addr;
  logic        setup_phase;
  logic        wr_access;
  logic        start_req;
  logic        done_rise;
  logic        start_rej;
  logic        xfer_done;
  logic        busy;
  logic [31:0] rdata;
  logic [1:0]  int_status_rd;
  logic [1:0]  int_en_rd;

  logic        unused_addr;

  assign word_addr   = paddr_i[11:2];
  assign unused_addr = ^paddr_i[1:0];
  assign setup_phase = psel_i & ~penable_i;
  assign wr_access   = psel_i & penable_i & pwrite_i;
  assign start_req   = wr_access & (word_addr == A_START) & pwdata_i[0];
  // Only a fresh rising edge of done counts; done_q resets high so the
  // engine's reset-high done is not mistaken for a completion.
  assign done_rise   = done_i & ~done_q;
  assign busy        = (state_q == ST_BUSY);

  assign pready_o    = 1'b1;
  assign prdata_o    = prdata_q;
  assign src_addr_o  = src_q;
  assign dst_addr_o  = dst_q;
  assign mat_width_o = width_q;
  assign start_o     = start_q;

  // Configuration SFR write decode; writes are allowed while busy because the
  // engine samples these only on the start pulse.
  always_comb begin
    src_d   = src_q;
    dst_d   = dst_q;
    width_d = width_q;
    if (wr_access) begin
      case (word_addr)
        A_SRC:   src_d   = pwdata_i;
        A_DST:   dst_d   = pwdata_i;
        A_WIDTH: width_d = pwdata_i[5:0];
        default: ;
      endcase
    end
  end

  // Busy FSM: start acceptance/rejection and completion detection.
  always_comb begin
    state_d   = state_q;
    start_d   = 1'b0;
    rej_d     = rej_q;
    start_rej = 1'b0;
    xfer_done = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_req) begin
          if (done_i && (width_q >= MIN_WIDTH)) begin
            state_d = ST_BUSY;
            start_d = 1'b1;
            rej_d   = 1'b0;
          end else begin
            rej_d     = 1'b1;
            start_rej = 1'b1;
          end
        end
      end
      ST_BUSY: begin
        // busy covers the cycle between start_o and the engine dropping done,
        // so a back-to-back request lands here and is rejected.
        if (start_req) begin
          rej_d     = 1'b1;
          start_rej = 1'b1;
        end
        if (done_rise) begin
          state_d   = ST_IDLE;
          xfer_done = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Read mux; unmapped and write-only offsets return 0.
  always_comb begin
    rdata = 32'd0;
    case (word_addr)
      A_VERSION: rdata = VERSION;
      A_SRC:     rdata = src_q;
      A_DST:     rdata = dst_q;
      A_WIDTH:   rdata = {26'd0, width_q};
      A_STATUS:  rdata = {29'd0, rej_q, busy, done_i};
      A_ISTAT:   rdata = {30'd0, int_status_rd};
      A_IEN:     rdata = {30'd0, int_en_rd};
      default:   rdata = 32'd0;
    endcase
  end

  // Read data is captured in the setup phase and held otherwise.
  always_comb begin
    prdata_d = prdata_q;
    if (setup_phase) begin
      prdata_d = rdata;
    end
  end

  // Core state registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      src_q    <= 32'd0;
      dst_q    <= 32'd0;
      width_q  <= 6'd0;
      rej_q    <= 1'b0;
      start_q  <= 1'b0;
      done_q   <= 1'b1;
      prdata_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      src_q    <= src_d;
      dst_q    <= dst_d;
      width_q  <= width_d;
      rej_q    <= rej_d;
      start_q  <= start_d;
      done_q   <= done_i;
      prdata_q <= prdata_d;
    end
  end

`ifdef MPDMAC_IRQ_EN
  logic [1:0] int_status_q, int_status_d;
  logic [1:0] int_en_q, int_en_d;
  logic       irq_q;

  // Interrupt status W1C with set-wins priority, plus enable register.
  always_comb begin
    int_status_d = int_status_q;
    int_en_d     = int_en_q;
    if (wr_access && (word_addr == A_ISTAT)) begin
      int_status_d = int_status_q & ~pwdata_i[1:0];
    end
    if (wr_access && (word_addr == A_IEN)) begin
      int_en_d = pwdata_i[1:0];
    end
    int_status_d = int_status_d | {start_rej, xfer_done};
  end

  // Interrupt registers; irq_o lags INT_STATUS by one cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      int_status_q <= 2'b00;
      int_en_q     <= 2'b00;
      irq_q        <= 1'b0;
    end else begin
      int_status_q <= int_status_d;
      int_en_q     <= int_en_d;
      irq_q        <= |(int_status_q & int_en_q);
    end
  end

  assign int_status_rd = int_status_q;
  assign int_en_rd     = int_en_q;
  assign irq_o         = irq_q;
`else
  logic unused_evt;

  assign unused_evt    = start_rej ^ xfer_done;
  assign int_status_rd = 2'b00;
  assign int_en_rd     = 2'b00;
  assign irq_o         = 1'b0;
`endif

endmodule

// File: tb/tb_mpdmac_cfg.sv
`timescale 1ns/1ps
// tb_mpdmac_cfg: directed scoreboard bench for mpdmac_cfg.
// Reads, start pulses and signal probes are queued by the driver and checked
// by a single negedge monitor. Expectations follow MPDMAC_IRQ_EN.

module tb_mpdmac_cfg;

`ifdef MPDMAC_IRQ_EN
  localparam bit IRQ = 1'b1;
`else
  localparam bit IRQ = 1'b0;
`endif

  localparam int DONE_LEN = 20;

  localparam int K_IRQ    = 0;
  localparam int K_START  = 1;
  localparam int K_PREADY = 2;
  localparam int K_PRDATA = 3;
  localparam int K_SRC    = 4;
  localparam int K_DST    = 5;
  localparam int K_WIDTH  = 6;
  localparam int K_FLAG   = 7;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        psel = 1'b0;
  logic        penable = 1'b0;
  logic [11:0] paddr = 12'd0;
  logic        pwrite = 1'b0;
  logic [31:0] pwdata = 32'd0;
  logic        pready;
  logic [31:0] prdata;
  logic [31:0] src_addr;
  logic [31:0] dst_addr;
  logic [5:0]  mat_width;
  logic        start_o;
  logic        done_sig;
  logic        irq;

  logic        engine_auto = 1'b1;
  logic        eng_done = 1'b1;
  logic        man_done = 1'b1;

  always #5 clk = ~clk;

  assign done_sig = engine_auto ? eng_done : man_done;

  mpdmac_cfg dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .psel_i      (psel),
    .penable_i   (penable),
    .paddr_i     (paddr),
    .pwrite_i    (pwrite),
    .pwdata_i    (pwdata),
    .pready_o    (pready),
    .prdata_o    (prdata),
    .src_addr_o  (src_addr),
    .dst_addr_o  (dst_addr),
    .mat_width_o (mat_width),
    .start_o     (start_o),
    .done_i      (done_sig),
    .irq_o       (irq)
  );

  // Engine model: drops done the cycle after a start pulse, raises it later.
  initial begin
    forever begin
      @(negedge clk);
      if (engine_auto && start_o) begin
        eng_done = 1'b0;
        repeat (DONE_LEN) @(negedge clk);
        eng_done = 1'b1;
      end
    end
  end

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];
  string       exp_name_q[$];
  logic [69:0] exp_start_q[$];
  int          probe_kind_q[$];
  logic [31:0] probe_exp_q[$];
  logic [31:0] probe_val_q[$];
  string       probe_name_q[$];
  int          checks = 0;
  int          errors = 0;
  logic        start_prev = 1'b0;
  logic        end_req = 1'b0;
  logic        end_done = 1'b0;

  // Monitor: compares every read, start pulse and queued probe.
  always @(negedge clk) begin
    logic [31:0] e;
    logic [31:0] a;
    logic [69:0] s;
    string       n;
    int          k;
    if (rst_n && psel && penable && !pwrite) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL read_unexpected: got %h expected nothing queued", prdata);
      end else begin
        e = exp_q.pop_front();
        n = exp_name_q.pop_front();
        if (prdata !== e) begin
          errors++;
          $display("FAIL %s: got %h expected %h", n, prdata, e);
        end
      end
    end
    if (start_o === 1'b1) begin
      checks++;
      if (exp_start_q.size() == 0) begin
        errors++;
        $display("FAIL start_unexpected: got pulse src=%h dst=%h w=%0d expected none",
                 src_addr, dst_addr, mat_width);
      end else begin
        s = exp_start_q.pop_front();
        if (({src_addr, dst_addr, mat_width} !== s) || start_prev) begin
          errors++;
          $display("FAIL start_pulse: got %h prev=%b expected %h prev=0",
                   {src_addr, dst_addr, mat_width}, start_prev, s);
        end
      end
    end
    start_prev = start_o;
    while (probe_kind_q.size() > 0) begin
      k = probe_kind_q.pop_front();
      e = probe_exp_q.pop_front();
      n = probe_name_q.pop_front();
      a = probe_val_q.pop_front();
      case (k)
        K_IRQ:    a = {31'd0, irq};
        K_START:  a = {31'd0, start_o};
        K_PREADY: a = {31'd0, pready};
        K_PRDATA: a = prdata;
        K_SRC:    a = src_addr;
        K_DST:    a = dst_addr;
        K_WIDTH:  a = {26'd0, mat_width};
        default:  ;
      endcase
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL %s: got %h expected %h", n, a, e);
      end
    end
    if (end_req && !end_done) begin
      checks++;
      if (exp_q.size() != 0) begin
        errors++;
        $display("FAIL reads_pending: got %0d expected 0", exp_q.size());
      end
      checks++;
      if (exp_start_q.size() != 0) begin
        errors++;
        $display("FAIL starts_missing: got %0d pending expected 0", exp_start_q.size());
      end
      end_done = 1'b1;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic apb_write(input logic [11:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apb_read(input logic [11:0] a, input logic [31:0] e, input string n);
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
    exp_q.push_back(e);
    exp_name_q.push_back(n);
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic probe(input int k, input logic [31:0] e, input string n);
    probe_kind_q.push_back(k);
    probe_exp_q.push_back(e);
    probe_val_q.push_back(32'd0);
    probe_name_q.push_back(n);
  endtask

  task automatic flag(input logic v, input string n);
    probe_kind_q.push_back(K_FLAG);
    probe_exp_q.push_back(32'd1);
    probe_val_q.push_back({31'd0, v});
    probe_name_q.push_back(n);
  endtask

  task automatic wait_done(input string n);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (done_sig) begin
        seen = 1'b1;
        break;
      end
    end
    flag(seen, n);
  endtask

  task automatic expect_start(input logic [31:0] s, input logic [31:0] d, input logic [5:0] w);
    exp_start_q.push_back({s, d, w});
  endtask

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected summary");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed sequence ----------------
  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    probe(K_START, 32'd0, "rst_start");
    probe(K_IRQ, 32'd0, "rst_irq");
    probe(K_PREADY, 32'd1, "rst_pready");
    probe(K_PRDATA, 32'd0, "rst_prdata");

    apb_read(12'h000, 32'h0001_2024, "rd_version");
    apb_read(12'h100, 32'h0, "rd_src_rst");
    apb_read(12'h110, 32'h1, "rd_status_rst");
    apb_write(12'h000, 32'hDEAD_BEEF);
    apb_write(12'h200, 32'h1234_5678);
    apb_read(12'h000, 32'h0001_2024, "rd_version_ro");
    apb_read(12'h200, 32'h0, "rd_unmapped");

    // Basic transfer.
    apb_write(12'h100, 32'h0000_1000);
    apb_write(12'h104, 32'h0000_2000);
    apb_write(12'h108, 32'hFFFF_FFC4);
    apb_write(12'h118, 32'h3);
    probe(K_SRC, 32'h1000, "src_out");
    probe(K_DST, 32'h2000, "dst_out");
    probe(K_WIDTH, 32'h4, "width_out");
    apb_read(12'h108, 32'h4, "rd_width_mask");
    apb_read(12'h118, IRQ ? 32'h3 : 32'h0, "rd_int_en");
    apb_read(12'h10C, 32'h0, "rd_start_wo");
    expect_start(32'h1000, 32'h2000, 6'd4);
    apb_write(12'h10C, 32'h1);
    apb_read(12'h110, 32'h2, "rd_status_busy");
    apb_write(12'h100, 32'h0000_3000);
    probe(K_SRC, 32'h3000, "src_write_busy");
    wait_done("xfer1_done");
    probe(K_IRQ, 32'd0, "irq_lag");
    @(posedge clk); #1;
    probe(K_IRQ, IRQ ? 32'd1 : 32'd0, "irq_complete");
    apb_read(12'h114, IRQ ? 32'h1 : 32'h0, "rd_int_complete");
    apb_read(12'h110, 32'h1, "rd_status_idle");

    // Back-to-back START: second one rejected.
    apb_write(12'h114, 32'h3);
    @(posedge clk); #1;
    probe(K_IRQ, 32'd0, "irq_clear");
    apb_read(12'h114, 32'h0, "rd_int_cleared");
    expect_start(32'h3000, 32'h2000, 6'd4);
    apb_write(12'h10C, 32'h1);
    apb_write(12'h10C, 32'h1);
    apb_read(12'h110, 32'h6, "rd_status_rej_busy");
    apb_read(12'h114, IRQ ? 32'h2 : 32'h0, "rd_int_rej");
    probe(K_IRQ, IRQ ? 32'd1 : 32'd0, "irq_rej");
    wait_done("xfer2_done");
    @(posedge clk); #1;
    apb_read(12'h114, IRQ ? 32'h3 : 32'h0, "rd_int_both");
    apb_read(12'h110, 32'h5, "rd_status_rej_idle");

    // W1C collides with completion: set wins.
    apb_write(12'h114, 32'h3);
    man_done = 1'b1;
    engine_auto = 1'b0;
    expect_start(32'h3000, 32'h2000, 6'd4);
    apb_write(12'h10C, 32'h1);
    man_done = 1'b0;
    apb_read(12'h110, 32'h2, "rd_status_rej_cleared");
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 12'h114; pwdata = 32'h1;
    @(posedge clk); #1;
    penable = 1'b1;
    man_done = 1'b1;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    apb_read(12'h114, IRQ ? 32'h1 : 32'h0, "rd_int_set_wins");
    probe(K_IRQ, IRQ ? 32'd1 : 32'd0, "irq_set_wins");
    apb_read(12'h110, 32'h1, "rd_status_manual_done");
    apb_write(12'h114, 32'h1);
    @(posedge clk); #1;
    probe(K_IRQ, 32'd0, "irq_w1c_fall");
    apb_read(12'h114, 32'h0, "rd_int_w1c");
    engine_auto = 1'b1;

    // Width below minimum: rejected while idle.
    apb_write(12'h108, 32'h2);
    apb_write(12'h10C, 32'h1);
    probe(K_START, 32'd0, "no_start_w2");
    apb_read(12'h110, 32'h5, "rd_status_w2");
    apb_read(12'h114, IRQ ? 32'h2 : 32'h0, "rd_int_w2");
    probe(K_IRQ, IRQ ? 32'd1 : 32'd0, "irq_w2");

    // Width exactly at minimum: accepted.
    apb_write(12'h114, 32'h3);
    apb_write(12'h108, 32'h3);
    expect_start(32'h3000, 32'h2000, 6'd3);
    apb_write(12'h10C, 32'h1);
    apb_read(12'h110, 32'h2, "rd_status_w3");
    wait_done("xfer_w3_done");
    @(posedge clk); #1;
    apb_read(12'h110, 32'h1, "rd_status_w3_idle");
    apb_read(12'h114, IRQ ? 32'h1 : 32'h0, "rd_int_w3");

    // Reset in the middle of a transfer.
    apb_write(12'h104, 32'h0000_4444);
    expect_start(32'h3000, 32'h4444, 6'd3);
    apb_write(12'h10C, 32'h1);
    apb_read(12'h110, 32'h2, "rd_status_pre_rst");
    @(posedge clk); #1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    probe(K_SRC, 32'd0, "src_after_rst");
    probe(K_WIDTH, 32'd0, "width_after_rst");
    probe(K_IRQ, 32'd0, "irq_after_rst");
    probe(K_PRDATA, 32'd0, "prdata_after_rst");
    apb_read(12'h110, 32'h0, "rd_status_abort");
    apb_read(12'h114, 32'h0, "rd_int_abort");
    wait_done("engine_done_after_rst");
    @(posedge clk); #1;
    apb_read(12'h114, 32'h0, "rd_int_no_report");
    apb_read(12'h110, 32'h1, "rd_status_final");
    repeat (3) @(posedge clk);
    #1 probe(K_PRDATA, 32'h1, "prdata_hold");

    // Final report.
    end_req = 1'b1;
    for (int i = 0; i < 10 && !end_done; i++) @(posedge clk);
    if (!end_done) begin
      $display("FAIL end_handshake: got no monitor response expected done");
      $fatal(1, "monitor did not respond");
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
